// File: rtl/delay_line_buffer.sv
// Multi-channel circular delay line: per-channel sample storage sharing one write pointer,
// with registered age-addressed reads, range checking and an output gate.
module delay_line_buffer #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned CHANNELS      = 2,
  parameter int unsigned ADDRESS_WIDTH = $clog2(DEPTH),
  parameter int unsigned CH_WIDTH      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     operational_clock,
  input  logic                     clear,
  input  logic                     write,
  input  logic [CH_WIDTH-1:0]      wr_channel,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     advance,
  input  logic                     read,
  input  logic [CH_WIDTH-1:0]      rd_channel,
  input  logic [ADDRESS_WIDTH-1:0] rd_delay,
  input  logic                     output_enable,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     rd_valid,
  output logic                     rd_error,
  output logic [ADDRESS_WIDTH:0]   fill_level,
  output logic [ADDRESS_WIDTH-1:0] wr_ptr
);

  localparam int unsigned ChSlots = 2 ** CH_WIDTH;
  localparam logic [ADDRESS_WIDTH:0] FillMax = (ADDRESS_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [CHANNELS][DEPTH];

  logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDRESS_WIDTH:0]   fill_q, fill_d;
  logic [DATA_WIDTH-1:0]    sample_q, sample_d;
  logic                     rd_valid_q, rd_valid_d;
  logic                     rd_error_q, rd_error_d;

  // Channel-select codes that map onto real storage.
  logic [ChSlots-1:0] ch_ok;
  for (genvar g = 0; g < ChSlots; g++) begin : g_ch_ok
    assign ch_ok[g] = (g < CHANNELS);
  end

  logic                     wr_en;
  logic                     rd_err;
  logic [CH_WIDTH-1:0]      rd_ch_idx;
  logic [ADDRESS_WIDTH-1:0] rd_addr;

  assign wr_en     = operational_clock & ~clear & write & ch_ok[wr_channel];
  // Age 0 is the slot just behind the write pointer, i.e. the last committed frame.
  assign rd_addr   = wr_ptr_q - ADDRESS_WIDTH'(1) - rd_delay;
  assign rd_err    = ({1'b0, rd_delay} >= fill_q) || !ch_ok[rd_channel];
  assign rd_ch_idx = ch_ok[rd_channel] ? rd_channel : '0;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    fill_d     = fill_q;
    sample_d   = sample_q;
    rd_error_d = rd_error_q;
    rd_valid_d = 1'b0;
    if (operational_clock && clear) begin
      wr_ptr_d = '0;
      fill_d   = '0;
    end else if (operational_clock) begin
      if (advance) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (fill_q != FillMax) fill_d = fill_q + 1'b1;
      end
      if (read) begin
        rd_valid_d = 1'b1;
        rd_error_d = rd_err;
        sample_d   = rd_err ? '0 : mem_q[rd_ch_idx][rd_addr];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      sample_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_error_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      sample_q   <= sample_d;
      rd_valid_q <= rd_valid_d;
      rd_error_q <= rd_error_d;
    end
  end

  // Storage is not reset; a same-cycle read sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_channel][wr_ptr_q] <= data_in;
  end

  assign data_out   = output_enable ? sample_q : '0;
  assign rd_valid   = rd_valid_q;
  assign rd_error   = rd_error_q;
  assign fill_level = fill_q;
  assign wr_ptr     = wr_ptr_q;

endmodule

// File: tb/tb_delay_line_buffer.sv
// Randomised and directed bench for delay_line_buffer with a queue-based scoreboard
// fed by a frame-history reference model.
module tb_delay_line_buffer;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int CH    = 2;
  localparam int AW    = 4;
  localparam int CW    = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          operational_clock = 1'b0;
  logic          clear = 1'b0;
  logic          write = 1'b0;
  logic [CW-1:0] wr_channel = '0;
  logic [DW-1:0] data_in = '0;
  logic          advance = 1'b0;
  logic          read = 1'b0;
  logic [CW-1:0] rd_channel = '0;
  logic [AW-1:0] rd_delay = '0;
  logic          output_enable = 1'b0;
  logic [DW-1:0] data_out;
  logic          rd_valid;
  logic          rd_error;
  logic [AW:0]   fill_level;
  logic [AW-1:0] wr_ptr;

  delay_line_buffer #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .CHANNELS(CH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .operational_clock(operational_clock),
    .clear(clear),
    .write(write),
    .wr_channel(wr_channel),
    .data_in(data_in),
    .advance(advance),
    .read(read),
    .rd_channel(rd_channel),
    .rd_delay(rd_delay),
    .output_enable(output_enable),
    .data_out(data_out),
    .rd_valid(rd_valid),
    .rd_error(rd_error),
    .fill_level(fill_level),
    .wr_ptr(wr_ptr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [DW-1:0] data;
    bit            err;
    bit            known;
  } exp_t;

  exp_t sb[$];

  // Reference model: slot contents per channel, commit position and committed-frame count.
  logic [DW-1:0] m_mem   [CH][DEPTH];
  bit            m_known [CH][DEPTH];
  int            m_ptr = 0;
  int            m_fill = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every rd_valid pulse must match the oldest outstanding read.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (rd_valid) begin
        if (sb.size() == 0) begin
          chk("rd_valid_unexpected", 32'(rd_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("rd_error", 32'(rd_error), 32'(e.err));
          if (e.known) chk("data_out", 32'(data_out), output_enable ? 32'(e.data) : 32'd0);
        end
      end else if (sb.size() != 0) begin
        chk("rd_valid_missing", 32'(rd_valid), 32'd1);
        sb.delete();
      end
    end
  end

  // Apply the model to the current inputs, clock once, then check pointer state.
  task automatic step();
    exp_t e;
    bit   pushed;
    int   addr;
    pushed = 0;
    if (operational_clock && rst_n) begin
      if (clear) begin
        m_ptr  = 0;
        m_fill = 0;
      end else begin
        if (read) begin
          addr    = (m_ptr - 1 - int'(rd_delay) + 2 * DEPTH) % DEPTH;
          e.err   = (int'(rd_delay) >= m_fill) || (int'(rd_channel) >= CH);
          e.data  = e.err ? '0 : m_mem[rd_channel][addr];
          e.known = e.err || m_known[rd_channel][addr];
          pushed  = 1;
        end
        if (write && int'(wr_channel) < CH) begin
          m_mem[wr_channel][m_ptr]   = data_in;
          m_known[wr_channel][m_ptr] = 1;
        end
        if (advance) begin
          m_ptr = (m_ptr + 1) % DEPTH;
          if (m_fill < DEPTH) m_fill++;
        end
      end
    end
    @(posedge clk);
    if (pushed) sb.push_back(e);
    #1;
    chk("wr_ptr", 32'(wr_ptr), 32'(m_ptr));
    chk("fill_level", 32'(fill_level), 32'(m_fill));
  endtask

  task automatic idle();
    write   = 1'b0;
    advance = 1'b0;
    read    = 1'b0;
    clear   = 1'b0;
  endtask

  initial begin
    operational_clock = 1'b1;
    output_enable     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("reset_fill", 32'(fill_level), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_data_out", 32'(data_out), 32'd0);
    rst_n = 1'b1;

    // Basic two-channel write, commit and read.
    write = 1'b1; wr_channel = 0; data_in = 16'h1111; step();
    wr_channel = 1; data_in = 16'h2222; step();
    idle(); advance = 1'b1; step();
    idle(); read = 1'b1; rd_channel = 1; rd_delay = 0; step();
    chk("basic_data", 32'(data_out), 32'h2222);
    chk("basic_valid", 32'(rd_valid), 32'd1);
    chk("basic_error", 32'(rd_error), 32'd0);
    chk("basic_fill", 32'(fill_level), 32'd1);
    idle(); clear = 1'b1; step();

    // Wrap: 20 frames into a 16-deep buffer.
    idle();
    for (int k = 0; k < 20; k++) begin
      write = 1'b1; advance = 1'b1; wr_channel = 0; data_in = DW'(k); step();
    end
    idle(); read = 1'b1; rd_channel = 0; rd_delay = 0; step();
    chk("wrap_newest", 32'(data_out), 32'd19);
    rd_delay = 15; step();
    chk("wrap_oldest", 32'(data_out), 32'd4);
    chk("wrap_wr_ptr", 32'(wr_ptr), 32'd4);
    chk("wrap_fill", 32'(fill_level), 32'd16);

    // Collision: delay 15 on a full buffer aliases the write slot.
    write = 1'b1; advance = 1'b1; wr_channel = 0; data_in = 16'hBEEF; step();
    chk("collide_old", 32'(data_out), 32'd4);
    idle(); read = 1'b1; rd_delay = 0; step();
    chk("collide_new", 32'(data_out), 32'hBEEF);

    // Range checking.
    idle(); clear = 1'b1; step();
    idle(); advance = 1'b1; repeat (3) step();
    idle(); read = 1'b1; rd_delay = 3; step();
    chk("range_err", 32'(rd_error), 32'd1);
    chk("range_zero", 32'(data_out), 32'd0);
    rd_delay = 2; step();
    chk("range_ok", 32'(rd_error), 32'd0);

    // Gating by operational_clock and output_enable.
    idle(); operational_clock = 1'b0; write = 1'b1; read = 1'b1; advance = 1'b1; step();
    chk("gate_rd_valid", 32'(rd_valid), 32'd0);
    idle(); operational_clock = 1'b1; output_enable = 1'b0; read = 1'b1; rd_delay = 1; step();
    chk("oe_data", 32'(data_out), 32'd0);
    chk("oe_valid", 32'(rd_valid), 32'd1);
    output_enable = 1'b1;

    // Asynchronous reset between edges, with a read result pending.
    idle(); read = 1'b1; rd_delay = 0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rd_valid", 32'(rd_valid), 32'd0);
    chk("arst_data", 32'(data_out), 32'd0);
    chk("arst_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("arst_fill", 32'(fill_level), 32'd0);
    chk("arst_err", 32'(rd_error), 32'd0);
    sb.delete();
    m_ptr = 0; m_fill = 0;
    rst_n = 1'b1;
    idle();

    // Clear after five commits.
    advance = 1'b1; repeat (5) step();
    idle(); clear = 1'b1; step();
    chk("clear_fill", 32'(fill_level), 32'd0);
    chk("clear_wr_ptr", 32'(wr_ptr), 32'd0);
    idle(); read = 1'b1; rd_delay = 0; step();
    chk("clear_err", 32'(rd_error), 32'd1);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      operational_clock = ($urandom_range(7) != 0);
      clear             = ($urandom_range(40) == 0);
      write             = $urandom_range(1);
      wr_channel        = CW'($urandom_range(CH - 1));
      data_in           = DW'($urandom);
      advance           = ($urandom_range(2) != 0);
      read              = $urandom_range(1);
      rd_channel        = CW'($urandom_range(CH - 1));
      rd_delay          = AW'($urandom_range(DEPTH - 1));
      output_enable     = ($urandom_range(3) != 0);
      step();
    end

    idle(); repeat (2) step();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
